fdc_meas_sequencer: RTL and testbench

Measurement sequencer for the FDC chip. It schedules gated edge-count windows on two asynchronous pulse inputs and shares one counter datapath between them by round-robin arbitration. Each result is returned with a valid/ready handshake. It sits between the `tt_um_fdc_chip` pin wrapper (`ui_in` pulse pins, `ena`) and the readout/output mux.

---
 rtl/fdc_meas_sequencer.sv | 158 +++++++++++++++
 tb/tb_fdc_meas_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_meas_sequencer.sv
// Gated edge-count sequencer: two asynchronous pulse inputs share one saturating
// counter via round-robin selection; each gate result is returned over valid/ready.
module fdc_meas_sequencer #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic [1:0]       sig_in,
  input  logic [1:0]       ch_en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             start,
  input  logic             continuous,
  input  logic             res_ready,
  output logic             res_valid,
  output logic [CNT_W-1:0] res_count,
  output logic             res_chan,
  output logic             res_ovf,
  output logic             busy,
  output logic             gate
);

  typedef enum logic [1:0] {ST_IDLE, ST_GATE, ST_HOLD} state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync1_q, sync1_d, sync2_q, sync2_d, hist_q, hist_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, res_count_q, res_count_d;
  logic             ovf_q, ovf_d, res_ovf_q, res_ovf_d;
  logic             chan_q, chan_d, res_chan_q, res_chan_d;
  logic             last_chan_q, last_chan_d;

  logic [1:0]       strobe;
  logic             sel_strobe;
  logic             can_run;
  logic             load;
  logic             pick;
  logic [WIN_W-1:0] win_load;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;

  // Saturating increment; an attempt at all-ones latches the overflow flag.
  function automatic logic [CNT_W:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                             input logic ovf, input logic inc);
    logic [CNT_W-1:0] ones;
    ones = '1;
    if (!inc)             sat_inc = {ovf, cnt};
    else if (cnt == ones) sat_inc = {1'b1, cnt};
    else                  sat_inc = {ovf, cnt + {{(CNT_W-1){1'b0}}, 1'b1}};
  endfunction

  function automatic logic pick_chan(input logic [1:0] en, input logic last);
    if (en == 2'b11) pick_chan = ~last;
    else             pick_chan = en[1];
  endfunction

  assign strobe     = sync2_q & ~hist_q;
  assign sel_strobe = strobe[chan_q];
  assign can_run    = ena & (|ch_en);
  assign pick       = pick_chan(ch_en, last_chan_q);
  assign win_load   = (win_len == '0) ? {{(WIN_W-1){1'b0}}, 1'b1} : win_len;
  assign {acc_ovf, acc_cnt} = sat_inc(cnt_q, ovf_q, sel_strobe);

  always_comb begin
    sync1_d     = sig_in;
    sync2_d     = sync1_q;
    hist_d      = sync2_q;
    state_d     = state_q;
    win_cnt_d   = win_cnt_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    chan_d      = chan_q;
    last_chan_d = last_chan_q;
    res_count_d = res_count_q;
    res_ovf_d   = res_ovf_q;
    res_chan_d  = res_chan_q;
    load        = 1'b0;

    if (!ena) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if ((start | continuous) & can_run) load = 1'b1;
        end
        ST_GATE: begin
          cnt_d     = acc_cnt;
          ovf_d     = acc_ovf;
          win_cnt_d = win_cnt_q - {{(WIN_W-1){1'b0}}, 1'b1};
          // The final gate cycle's strobe is folded into the published result.
          if (win_cnt_q == {{(WIN_W-1){1'b0}}, 1'b1}) begin
            state_d     = ST_HOLD;
            res_count_d = acc_cnt;
            res_ovf_d   = acc_ovf;
            res_chan_d  = chan_q;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            if (continuous & can_run) load = 1'b1;
            else                      state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (load) begin
      state_d     = ST_GATE;
      chan_d      = pick;
      last_chan_d = pick;
      win_cnt_d   = win_load;
      cnt_d       = '0;
      ovf_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      hist_q      <= '0;
      win_cnt_q   <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      chan_q      <= 1'b0;
      last_chan_q <= 1'b1;
      res_count_q <= '0;
      res_ovf_q   <= 1'b0;
      res_chan_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      hist_q      <= hist_d;
      win_cnt_q   <= win_cnt_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      chan_q      <= chan_d;
      last_chan_q <= last_chan_d;
      res_count_q <= res_count_d;
      res_ovf_q   <= res_ovf_d;
      res_chan_q  <= res_chan_d;
    end
  end

  assign res_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign gate      = (state_q == ST_GATE);
  assign res_count = res_count_q;
  assign res_chan  = res_chan_q;
  assign res_ovf   = res_ovf_q;

endmodule

// File: tb/tb_fdc_meas_sequencer.sv
// Scoreboard bench for fdc_meas_sequencer: stimulus queues expected results,
// a negedge monitor pops and compares on every valid/ready transfer.
module tb_fdc_meas_sequencer;
  localparam int CNT_W = 4;
  localparam int WIN_W = 16;

  logic             clk = 1'b0;
  logic             rst_n, ena, start, continuous, res_ready;
  logic [1:0]       sig_in, ch_en;
  logic [WIN_W-1:0] win_len;
  logic             res_valid, res_chan, res_ovf, busy, gate;
  logic [CNT_W-1:0] res_count;

  typedef struct packed {
    logic [CNT_W-1:0] cnt;
    logic             chan;
    logic             ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   per[2];
  int   ph[2];

  fdc_meas_sequencer #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sig_in(sig_in), .ch_en(ch_en),
    .win_len(win_len), .start(start), .continuous(continuous),
    .res_ready(res_ready), .res_valid(res_valid), .res_count(res_count),
    .res_chan(res_chan), .res_ovf(res_ovf), .busy(busy), .gate(gate)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input int cnt, input bit chan, input bit ovf);
    exp_t e;
    e.cnt  = CNT_W'(cnt);
    e.chan = chan;
    e.ovf  = ovf;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, input string name, output int t);
    t = -1;
    for (int i = 0; i < maxc; i++) begin
      if (res_valid === 1'b1) begin
        t = cyc;
        break;
      end
      tick();
    end
    if (t < 0) check({name, "_timeout"}, 0, 1);
  endtask

  // Square-wave pulse sources, updated on the falling edge
  initial begin
    sig_in = 2'b00;
    ph[0] = 0;
    ph[1] = 0;
    forever begin
      @(negedge clk);
      for (int c = 0; c < 2; c++) begin
        if (per[c] == 0) begin
          sig_in[c] = 1'b0;
          ph[c] = 0;
        end else begin
          ph[c] = (ph[c] + 1) % per[c];
          sig_in[c] = (ph[c] < per[c] / 2);
        end
      end
    end
  end

  // Monitor: a transfer happens on the next rising edge when valid & ready
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("res_count", int'(res_count), int'(e.cnt));
          check("res_chan", int'(res_chan), int'(e.chan));
          check("res_ovf", int'(res_ovf), int'(e.ovf));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3, t4, gcnt, vcnt;
    rst_n = 1'b0; ena = 1'b1; ch_en = 2'b00; win_len = '0;
    start = 1'b0; continuous = 1'b0; res_ready = 1'b0;
    per[0] = 0; per[1] = 0;
    repeat (3) tick();
    check("rst_valid", int'(res_valid), 0);
    check("rst_count", int'(res_count), 0);
    check("rst_chan", int'(res_chan), 0);
    check("rst_ovf", int'(res_ovf), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_gate", int'(gate), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // No channel enabled: trigger must be ignored
    start = 1'b1;
    repeat (2) tick();
    check("noch_busy", int'(busy), 0);
    start = 1'b0;

    // Single-shot on ch0, consumer initially stalled
    ch_en = 2'b01; win_len = 12; per[0] = 4;
    repeat (8) tick();
    sb_q.push_back(mk(3, 1'b0, 1'b0));
    pulse_start();
    t0 = cyc;
    gcnt = 0;
    check("ss_gate_first", int'(gate), 1);
    for (int i = 0; i < 40; i++) begin
      if (res_valid === 1'b1) break;
      if (gate === 1'b1) gcnt++;
      tick();
    end
    check("ss_latency", cyc - t0, 12);
    check("ss_gate_len", gcnt, 12);
    repeat (5) begin
      tick();
      check("ss_hold_valid", int'(res_valid), 1);
      check("ss_hold_count", int'(res_count), 3);
    end
    res_ready = 1'b1;
    tick();
    check("ss_clear", int'(res_valid), 0);
    check("ss_idle_busy", int'(busy), 0);

    // Asynchronous reset in the middle of a gate
    win_len = 20;
    pulse_start();
    repeat (3) tick();
    check("rstg_busy_before", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rstg_valid", int'(res_valid), 0);
    check("rstg_count", int'(res_count), 0);
    check("rstg_chan", int'(res_chan), 0);
    check("rstg_ovf", int'(res_ovf), 0);
    check("rstg_busy", int'(busy), 0);
    check("rstg_gate", int'(gate), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Round-robin continuous: first gate after reset serves ch0
    per[0] = 0; per[1] = 2; ch_en = 2'b11; win_len = 8; res_ready = 1'b1;
    repeat (6) tick();
    sb_q.push_back(mk(0, 1'b0, 1'b0));
    sb_q.push_back(mk(4, 1'b1, 1'b0));
    sb_q.push_back(mk(0, 1'b0, 1'b0));
    sb_q.push_back(mk(4, 1'b1, 1'b0));
    continuous = 1'b1;
    wait_valid(30, "rr1", t1);
    tick();
    check("rr_no_idle", int'(gate), 1);
    wait_valid(30, "rr2", t2);
    check("rr_period_a", t2 - t1, 9);
    tick();
    wait_valid(30, "rr3", t3);
    check("rr_period_b", t3 - t2, 9);
    tick();
    continuous = 1'b0;
    wait_valid(30, "rr4", t4);
    tick();
    check("rr_stop_busy", int'(busy), 0);

    // Saturation with a 4-bit counter
    per[1] = 0; per[0] = 2; ch_en = 2'b01; win_len = 40;
    repeat (6) tick();
    sb_q.push_back(mk(15, 1'b0, 1'b1));
    pulse_start();
    wait_valid(60, "sat", t1);
    tick();
    check("sat_done_busy", int'(busy), 0);

    // Zero-length window behaves as one cycle
    per[0] = 0; win_len = 0;
    repeat (6) tick();
    sb_q.push_back(mk(0, 1'b0, 1'b0));
    pulse_start();
    check("zw_gate", int'(gate), 1);
    check("zw_valid_early", int'(res_valid), 0);
    tick();
    check("zw_gate_off", int'(gate), 0);
    check("zw_valid", int'(res_valid), 1);
    tick();
    check("zw_done", int'(res_valid), 0);

    // Second start during GATE must not queue another result
    win_len = 10;
    sb_q.push_back(mk(0, 1'b0, 1'b0));
    pulse_start();
    repeat (3) tick();
    pulse_start();
    wait_valid(30, "ign", t1);
    tick();
    vcnt = 0;
    repeat (20) begin
      tick();
      if (res_valid === 1'b1) vcnt++;
    end
    check("ign_extra", vcnt, 0);

    // ena dropped mid-gate aborts without a result
    pulse_start();
    repeat (3) tick();
    check("ab_busy_before", int'(busy), 1);
    ena = 1'b0;
    tick();
    check("ab_busy", int'(busy), 0);
    check("ab_gate", int'(gate), 0);
    check("ab_valid", int'(res_valid), 0);
    vcnt = 0;
    repeat (15) begin
      tick();
      if (res_valid === 1'b1) vcnt++;
    end
    check("ab_no_valid", vcnt, 0);
    ena = 1'b1;
    repeat (3) tick();
    check("ab_stays_idle", int'(busy), 0);

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
